// File: rtl/hexfp_mult_seq.sv
// Sequential base-16 floating-point multiplier, one multiplier hex digit per cycle.
// Latency: MANT_DIGITS+1 edges from the accepting edge to done (7 at defaults).
// Backpressure: start is sampled only in IDLE; start while busy is ignored.
module hexfp_mult_seq #(
  parameter int EXP_WIDTH   = 7,
  parameter int MANT_DIGITS = 6,
  parameter int BIAS        = 64
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [EXP_WIDTH+4*MANT_DIGITS:0]     dataa,
  input  logic [EXP_WIDTH+4*MANT_DIGITS:0]     datab,
  output logic                                 busy,
  output logic                                 done,
  output logic [EXP_WIDTH+4*MANT_DIGITS:0]     result,
  output logic                                 zero,
  output logic                                 overflow,
  output logic                                 underflow
);

  localparam int D    = MANT_DIGITS;
  localparam int FW   = 4 * D;                  // fraction width
  localparam int W    = 1 + EXP_WIDTH + FW;     // word width
  localparam int AW   = 8 * D;                  // exact product width
  localparam int EW2  = EXP_WIDTH + 2;          // adjusted operand exponent width
  localparam int EXTW = EXP_WIDTH + 3;          // result exponent working width
  localparam int LZW  = $clog2(D + 1);
  localparam int CW   = (D > 1) ? $clog2(D) : 1;

  // Largest encodable biased exponent, widened for comparison against Er.
  localparam logic [EW2-1:0] EMAX = EW2'((1 << EXP_WIDTH) - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_PACK = 2'd2
  } state_t;

  // Count of leading all-zero hex digits; a zero fraction yields D.
  function automatic logic [LZW-1:0] lead_zero_digits(input logic [FW-1:0] f);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = D - 1; i >= 0; i--) begin
      if (!found) begin
        if (f[4*i +: 4] != 4'h0) begin
          found = 1'b1;
        end else begin
          n = n + LZW'(1);
        end
      end
    end
    return n;
  endfunction

  // Operand field split.
  logic                 sa, sb;
  logic [EXP_WIDTH-1:0] ea, eb;
  logic [FW-1:0]        fa, fb;

  assign sa = dataa[W-1];
  assign sb = datab[W-1];
  assign ea = dataa[W-2 -: EXP_WIDTH];
  assign eb = datab[W-2 -: EXP_WIDTH];
  assign fa = dataa[FW-1:0];
  assign fb = datab[FW-1:0];

  // Registered state.
  state_t               state_q, state_d;
  logic                 sign_q, sign_d;
  logic                 zflag_q, zflag_d;
  logic [FW-1:0]        fa_q, fa_d;
  logic [FW-1:0]        fb_q, fb_d;
  logic [EW2-1:0]       ea_q, ea_d;
  logic [EW2-1:0]       eb_q, eb_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [W-1:0]         result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  // Pre-normalisation terms for the operands on the input pins.
  logic [LZW-1:0]       lza, lzb;
  logic [FW-1:0]        fa_norm, fb_norm;
  logic [EW2-1:0]       ea_adj, eb_adj;

  // Datapath terms for the current MUL / PACK cycle.
  logic [3:0]           digit;
  logic [FW+3:0]        pprod;
  logic                 top_zero;
  logic [FW-1:0]        frac;
  logic [EXTW-1:0]      er;
  logic                 er_neg;
  logic                 er_big;

  // Shift each operand so its leading hex digit is non-zero, compensating the exponent.
  always_comb begin
    lza     = lead_zero_digits(fa);
    lzb     = lead_zero_digits(fb);
    fa_norm = fa << {lza, 2'b00};
    fb_norm = fb << {lzb, 2'b00};
    ea_adj  = {2'b00, ea} - EW2'(lza);
    eb_adj  = {2'b00, eb} - EW2'(lzb);
  end

  // Partial product of the multiplicand with the current top multiplier digit.
  always_comb begin
    digit = fb_q[FW-1 -: 4];
    pprod = {4'h0, fa_q} * {{FW{1'b0}}, digit};
  end

  // Post-normalise and exponent range classification of the finished product.
  always_comb begin
    top_zero = (acc_q[AW-1 -: 4] == 4'h0);
    if (top_zero) begin
      frac = acc_q[AW-5 -: FW];
    end else begin
      frac = acc_q[AW-1 -: FW];
    end
    er = {ea_q[EW2-1], ea_q} + {eb_q[EW2-1], eb_q}
         - EXTW'(BIAS) - {{(EXTW-1){1'b0}}, top_zero};
    er_neg = er[EXTW-1];
    er_big = !er_neg && (er[EXTW-2:0] > EMAX);
  end

  // Next-state and next-output logic for the IDLE -> MUL -> PACK sequence.
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    zflag_d  = zflag_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = sa ^ sb;
          zflag_d = (fa == '0) || (fb == '0);
          fa_d    = fa_norm;
          fb_d    = fb_norm;
          ea_d    = ea_adj;
          eb_d    = eb_adj;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        // Multiplier is consumed MSB digit first, so the accumulator shifts up each step.
        acc_d = (acc_q << 4) + AW'(pprod);
        fb_d  = fb_q << 4;
        if (cnt_q == CW'(D - 1)) begin
          cnt_d   = '0;
          state_d = S_PACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_PACK: begin
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (zflag_q) begin
          result_d = '0;
          zero_d   = 1'b1;
        end else if (er_neg) begin
          result_d = '0;
          unf_d    = 1'b1;
          zero_d   = 1'b1;
        end else if (er_big) begin
          result_d = {sign_q, {EXP_WIDTH{1'b1}}, {FW{1'b1}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, er[EXP_WIDTH-1:0], frac};
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State register with synchronous reset that discards any in-flight operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      zflag_q  <= 1'b0;
      fa_q     <= '0;
      fb_q     <= '0;
      ea_q     <= '0;
      eb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      zflag_q  <= zflag_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/hexfp_mult_seq.md
Name: hexfp_mult_seq

Overview:
- Parametrised, sequential successor to the single-cycle hex-float multiplier in the Project 5 datapath.
- Multiplies two base-16 floating-point words iteratively, one multiplier hex digit per cycle, with a start/busy/done handshake.
- Adds operand pre-normalisation, correct sign, exact product, a single post-normalise shift, zero handling and overflow/underflow saturation.
- Word layout, MSB first: sign | exponent (EXP_WIDTH) | fraction (4*MANT_DIGITS).
- Value = (-1)^s × 0.F × 16^(E − BIAS).

Parameters:
- EXP_WIDTH, 7, exponent field width in bits.
- MANT_DIGITS, 6, fraction width in hex digits (D). Word width W = 1+EXP_WIDTH+4*D, which is 32 at the defaults.
- BIAS, 64, exponent excess.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- dataa  in  W  operand A; sampled on the accepting edge.
- datab  in  W  operand B; sampled on the accepting edge.
- busy  out  1  high while an operation is in flight (state != IDLE).
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- result  out  W  product; held until the next done.
- zero  out  1  result is true zero; held with result.
- overflow  out  1  exponent overflow; saturated result; held with result.
- underflow  out  1  exponent underflow; result flushed to zero; held with result.

Behaviour:
- Reset, synchronous, wins over everything including mid-operation:
  - state = IDLE.
  - busy = 0, done = 0, result = 0, all flags = 0.
  - Accumulator and counter are cleared.
  - The in-flight operation is discarded; no done is produced for it.
- FSM states: IDLE, MUL, PACK.
- IDLE, on edge k with start = 1:
  - Latch sign = sa XOR sb.
  - Leading-zero digits lza/lzb are found combinationally. Latch Fa<<4*lza and Fb<<4*lzb, and Ea' = Ea − lza and Eb' = Eb − lzb, signed, EXP_WIDTH+2 bits.
  - Latch zflag = (Fa == 0) OR (Fb == 0).
  - Clear acc (8*D bits) and cnt, then go to MUL.
  - start = 0 keeps the block in IDLE.
- MUL, D cycles:
  - Each edge: acc <= (acc << 4) + Fa × Fb digit[D−1−cnt], MSB digit first; cnt++.
  - After D edges acc = Fa×Fb exactly; go to PACK.
- PACK, one edge:
  - If acc top digit == 0: frac = acc[8D−5 : 4D−4], n = 1. Otherwise frac = acc[8D−1 : 4D], n = 0. Low digits are truncated; there is no rounding.
  - Er = Ea' + Eb' − BIAS − n, signed.
  - Priority zflag > underflow > overflow:
    - zflag: result = all zeros, sign 0; zero = 1.
    - Er < 0: result = 0, underflow = 1, zero = 1.
    - Er > 2^EXP_WIDTH − 1: result = {sign, all-ones exponent, all-ones fraction}, overflow = 1.
    - Otherwise: result = {sign, Er[EXP_WIDTH−1:0], frac}.
  - done <= 1, then go to IDLE.
- Latency:
  - Fixed at D+1 edges after the accepting edge; done is high in the cycle following edge k+D+1 (7 cycles at defaults).
  - Zero operands take the same latency.
- Handshake:
  - busy = 1 in the cycles following edges k … k+D; busy = 0 while done is high.
  - start while busy is ignored; operands need not be held after acceptance.
  - start during the done cycle is accepted, giving back-to-back throughput of one result per D+2 cycles.
- done lasts exactly one cycle. result and flags are stable until the next PACK.

Test Plan:
- Basic multiply and post-normalise shift:
  - 0x41100000 × 0x41200000 (1×2) → 0x41200000, flags 0, done 7 cycles after start, busy high for the 7 preceding cycles.
  - 0xC1300000 × 0x41400000 (−3×4) → 0xC1C00000.
  - 0x42100000 × 0x42100000 (16×16) → 0x43100000.
- No shift needed: 0x41F00000 × 0x41F00000 (15×15) → 0x42E10000.
- Unnormalised operand and zero:
  - 0x41010000 × 0x41200000 → 0x40200000.
  - 0x00000000 × 0x41200000 → 0x00000000 with zero = 1.
- Range limits:
  - 0x7F100000 × 0x7F100000 → 0x7FFFFFFF with overflow = 1.
  - 0x01100000 × 0x01100000 → 0x00000000 with underflow = 1 and zero = 1.
- Handshake:
  - start pulsed while busy → ignored, first result unchanged.
  - start asserted during the done cycle → second result after another 7 cycles.
- Reset mid-MUL (cycle 3) → next cycle busy = 0, done = 0, result = 0; no spurious done; a new start completes normally.
